// File: rtl/wb_sequencer_pkg.sv
// Shared definitions for the writeback sequencer.
// Holds the ALU opcode encoding (shared with the ALU), the sequencer state
// encoding and a small helper that classifies exception-capable opcodes.
package wb_sequencer_pkg;

  // ALU opcode encoding; 101-111 all decode as OR.
  localparam logic [2:0] AluAdd  = 3'b000;
  localparam logic [2:0] AluSub  = 3'b001;
  localparam logic [2:0] AluMove = 3'b010;
  localparam logic [2:0] AluSwap = 3'b011;
  localparam logic [2:0] AluAnd  = 3'b100;
  localparam logic [2:0] AluOr   = 3'b101;

  localparam logic [7:0] ExcCntMax = 8'hFF;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWrLo = 2'b01,
    StWrHi = 2'b10
  } seq_state_e;

  // Only ADD and SUB can raise an overflow exception.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == AluAdd) || (op == AluSub);
  endfunction

endpackage

// File: rtl/wb_sequencer_sat_counter8.sv
// sat_counter8: 8-bit up counter that saturates at 255 instead of wrapping.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset, clears count
//   inc   - increment request for this cycle
//   count - current count value
module sat_counter8
  import wb_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  output logic [7:0] count
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != ExcCntMax)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/wb_sequencer.sv
// wb_sequencer: writeback-stage sequencer driving a single register-file
// write port. Normal ops write alu_result[15:0] to rd one cycle after accept;
// SWAP takes a second cycle to write alu_result[31:16] to rs and stalls the
// pipeline for that cycle. ADD/SUB overflow suppresses the write, pulses
// exc_ovf and bumps a saturating exception counter.
// Ports:
//   clk, rst                       - clock / asynchronous active-high reset
//   wb_valid, wb_ready             - writeback handshake
//   alu_ctrl, alu_result           - opcode and result ([31:16] swap operand)
//   alu_overflow, reg_write        - ALU overflow flag, write-enable request
//   rd_addr, rs_addr               - destination / source register indices
//   rf_we, rf_waddr, rf_wdata      - register-file write port
//   exc_ovf, exc_cnt               - exception pulse and saturating count
module wb_sequencer
  import wb_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [2:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic        alu_overflow,
  input  logic        reg_write,
  input  logic [3:0]  rd_addr,
  input  logic [3:0]  rs_addr,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic        exc_ovf,
  output logic [7:0]  exc_cnt
);

  seq_state_e  state_q, state_d;
  logic [2:0]  ctrl_q;
  logic [31:0] result_q;
  logic        ovf_q;
  logic        regw_q;
  logic [3:0]  rd_q;
  logic [3:0]  rs_q;
  logic        accept;
  logic        exc;

  // Ready depends only on registered state, so there is no path from
  // wb_valid back to wb_ready.
  assign wb_ready = (state_q != StWrLo) || (ctrl_q != AluSwap);
  assign accept   = wb_valid && wb_ready;

  // Exceptions are only evaluated in the low-write cycle; SWAP never raises one.
  assign exc = (state_q == StWrLo) && is_arith(ctrl_q) && ovf_q;

  always_comb begin
    state_d  = state_q;
    rf_we    = 1'b0;
    rf_waddr = 4'd0;
    rf_wdata = 16'd0;
    exc_ovf  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StWrLo;
      end
      StWrLo: begin
        exc_ovf = exc;
        if (regw_q && !exc) begin
          rf_we    = 1'b1;
          rf_waddr = rd_q;
          rf_wdata = result_q[15:0];
        end
        if (ctrl_q == AluSwap) begin
          state_d = StWrHi;
        end else if (accept) begin
          state_d = StWrLo;
        end else begin
          state_d = StIdle;
        end
      end
      StWrHi: begin
        if (regw_q) begin
          rf_we    = 1'b1;
          rf_waddr = rs_q;
          rf_wdata = result_q[31:16];
        end
        state_d = accept ? StWrLo : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      ctrl_q   <= 3'd0;
      result_q <= 32'd0;
      ovf_q    <= 1'b0;
      regw_q   <= 1'b0;
      rd_q     <= 4'd0;
      rs_q     <= 4'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ctrl_q   <= alu_ctrl;
        result_q <= alu_result;
        ovf_q    <= alu_overflow;
        regw_q   <= reg_write;
        rd_q     <= rd_addr;
        rs_q     <= rs_addr;
      end
    end
  end

  sat_counter8 u_exc_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (exc),
    .count (exc_cnt)
  );

endmodule

// File: tb/tb_wb_sequencer.sv
// Directed self-checking bench for wb_sequencer.
module tb_wb_sequencer;
  import wb_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_valid = 1'b0;
  logic        wb_ready;
  logic [2:0]  alu_ctrl = 3'd0;
  logic [31:0] alu_result = 32'd0;
  logic        alu_overflow = 1'b0;
  logic        reg_write = 1'b0;
  logic [3:0]  rd_addr = 4'd0;
  logic [3:0]  rs_addr = 4'd0;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        exc_ovf;
  logic [7:0]  exc_cnt;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  wb_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .alu_ctrl     (alu_ctrl),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow),
    .reg_write    (reg_write),
    .rd_addr      (rd_addr),
    .rs_addr      (rs_addr),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .exc_ovf      (exc_ovf),
    .exc_cnt      (exc_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] res,
                       input logic ovf, input logic rw, input logic [3:0] rd,
                       input logic [3:0] rs);
    wb_valid     = v;
    alu_ctrl     = op;
    alu_result   = res;
    alu_overflow = ovf;
    reg_write    = rw;
    rd_addr      = rd;
    rs_addr      = rs;
  endtask

  task automatic idle_in();
    drive(1'b0, AluAnd, 32'd0, 1'b0, 1'b0, 4'd0, 4'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the full write port in one call.
  task automatic chk_wr(input string tag, input logic we, input logic [3:0] wa,
                        input logic [15:0] wd, input logic rdy);
    chk({tag, ".we"}, {31'd0, rf_we}, {31'd0, we});
    chk({tag, ".waddr"}, {28'd0, rf_waddr}, {28'd0, wa});
    chk({tag, ".wdata"}, {16'd0, rf_wdata}, {16'd0, wd});
    chk({tag, ".ready"}, {31'd0, wb_ready}, {31'd0, rdy});
  endtask

  initial begin
    // Reset state
    #1;
    chk_wr("rst_hold", 1'b0, 4'd0, 16'h0, 1'b1);
    chk("rst_hold.exc_ovf", {31'd0, exc_ovf}, 32'd0);
    chk("rst_hold.exc_cnt", {24'd0, exc_cnt}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_wr("post_rst", 1'b0, 4'd0, 16'h0, 1'b1);

    // ADD basic write
    drive(1'b1, AluAdd, 32'h0000_1234, 1'b0, 1'b1, 4'd3, 4'd0);
    tick();
    idle_in();
    chk_wr("add", 1'b1, 4'd3, 16'h1234, 1'b1);
    chk("add.exc_ovf", {31'd0, exc_ovf}, 32'd0);
    tick();
    chk_wr("add_idle", 1'b0, 4'd0, 16'h0, 1'b1);

    // SWAP two-cycle write
    drive(1'b1, AluSwap, 32'hBEEF_CAFE, 1'b0, 1'b1, 4'd1, 4'd2);
    tick();
    idle_in();
    chk_wr("swap_lo", 1'b1, 4'd1, 16'hCAFE, 1'b0);
    tick();
    chk_wr("swap_hi", 1'b1, 4'd2, 16'hBEEF, 1'b1);
    tick();
    chk_wr("swap_idle", 1'b0, 4'd0, 16'h0, 1'b1);

    // SWAP with rd==rs: low then high to the same register
    drive(1'b1, AluSwap, 32'h1111_2222, 1'b0, 1'b1, 4'd6, 4'd6);
    tick();
    idle_in();
    chk_wr("swap_same_lo", 1'b1, 4'd6, 16'h2222, 1'b0);
    tick();
    chk_wr("swap_same_hi", 1'b1, 4'd6, 16'h1111, 1'b1);
    tick();

    // SWAP without reg_write still spends the high cycle
    drive(1'b1, AluSwap, 32'h3333_4444, 1'b0, 1'b0, 4'd8, 4'd9);
    tick();
    idle_in();
    chk_wr("swap_nowr_lo", 1'b0, 4'd0, 16'h0, 1'b0);
    tick();
    chk_wr("swap_nowr_hi", 1'b0, 4'd0, 16'h0, 1'b1);
    tick();

    // SUB overflow raises exception
    drive(1'b1, AluSub, 32'h0000_0007, 1'b1, 1'b1, 4'd5, 4'd0);
    tick();
    idle_in();
    chk_wr("sub_ovf", 1'b0, 4'd0, 16'h0, 1'b1);
    chk("sub_ovf.exc_ovf", {31'd0, exc_ovf}, 32'd1);
    chk("sub_ovf.cnt_before", {24'd0, exc_cnt}, 32'd0);
    tick();
    chk("sub_ovf.pulse_end", {31'd0, exc_ovf}, 32'd0);
    chk("sub_ovf.cnt_after", {24'd0, exc_cnt}, 32'd1);

    // MOVE overflow is ignored
    drive(1'b1, AluMove, 32'h0000_55AA, 1'b1, 1'b1, 4'd7, 4'd0);
    tick();
    idle_in();
    chk_wr("move_ovf", 1'b1, 4'd7, 16'h55AA, 1'b1);
    chk("move_ovf.exc_ovf", {31'd0, exc_ovf}, 32'd0);
    tick();
    chk("move_ovf.cnt", {24'd0, exc_cnt}, 32'd1);

    // 260 back-to-back overflowing ADDs; counter starts at 1 and saturates
    drive(1'b1, AluAdd, 32'h0000_FFFF, 1'b1, 1'b1, 4'd4, 4'd0);
    for (int i = 0; i < 260; i++) begin
      tick();
      if (i == 259) idle_in();
      chk("add_sat.exc_ovf", {31'd0, exc_ovf}, 32'd1);
      chk("add_sat.we", {31'd0, rf_we}, 32'd0);
      chk("add_sat.cnt", {24'd0, exc_cnt}, (i + 1 > 255) ? 32'd255 : 32'(i + 1));
    end
    tick();
    chk("add_sat.final", {24'd0, exc_cnt}, 32'd255);
    chk("add_sat.pulse_end", {31'd0, exc_ovf}, 32'd0);

    // Reset in the low-write cycle of a SWAP
    drive(1'b1, AluSwap, 32'hDEAD_BEEF, 1'b0, 1'b1, 4'd10, 4'd11);
    tick();
    idle_in();
    chk_wr("rst_swap_lo", 1'b1, 4'd10, 16'hBEEF, 1'b0);
    rst = 1'b1;
    #1;
    chk_wr("rst_swap_async", 1'b0, 4'd0, 16'h0, 1'b1);
    chk("rst_swap.exc_cnt", {24'd0, exc_cnt}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk_wr("rst_swap_no_hi", 1'b0, 4'd0, 16'h0, 1'b1);
    chk("rst_swap.exc_ovf", {31'd0, exc_ovf}, 32'd0);
    tick();
    chk_wr("rst_swap_idle", 1'b0, 4'd0, 16'h0, 1'b1);

    // AND, OR, SWAP, ADD issued continuously
    drive(1'b1, AluAnd, 32'h0000_0011, 1'b0, 1'b1, 4'd1, 4'd0);
    tick();
    chk_wr("seq_and", 1'b1, 4'd1, 16'h0011, 1'b1);
    drive(1'b1, AluOr, 32'h0000_0022, 1'b0, 1'b1, 4'd2, 4'd0);
    tick();
    chk_wr("seq_or", 1'b1, 4'd2, 16'h0022, 1'b1);
    drive(1'b1, AluSwap, 32'hAAAA_BBBB, 1'b0, 1'b1, 4'd3, 4'd4);
    tick();
    drive(1'b1, AluAdd, 32'h0000_0044, 1'b0, 1'b1, 4'd5, 4'd0);
    chk_wr("seq_swap_lo", 1'b1, 4'd3, 16'hBBBB, 1'b0);
    tick();
    chk_wr("seq_swap_hi", 1'b1, 4'd4, 16'hAAAA, 1'b1);
    tick();
    idle_in();
    chk_wr("seq_add", 1'b1, 4'd5, 16'h0044, 1'b1);
    tick();
    chk_wr("seq_idle", 1'b0, 4'd0, 16'h0, 1'b1);
    chk("seq.exc_cnt", {24'd0, exc_cnt}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
